// File: rtl/logarithmic_afpm.sv
// Approximate FP16 multiplier (Mitchell logarithmic method) behind a byte-serial
// Tiny Tapeout style pin interface. One fixed 4-cycle frame per multiplication:
// load low bytes, load high bytes, emit low product byte, emit high product byte.
`timescale 1ns/1ps
module logarithmic_afpm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {StLoadLo, StLoadHi, StOutLo, StOutHi} state_e;

    // FP16 exponent bias (15) placed in the exponent field: 15 << 10.
    localparam logic signed [16:0] BiasL  = 17'sd15360;
    localparam logic signed [16:0] OvfL   = 17'sd31744;  // 0x7C00
    localparam logic signed [16:0] UnfL   = 17'sd1024;   // 0x0400
    localparam logic [15:0]        QNaN   = 16'h7E00;

    state_e      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] p_q, p_d;
    logic [7:0]  uo_q, uo_d;
    logic [15:0] prod;

    // Combinational Mitchell product of the fully loaded operands.
    always_comb begin
        logic               sgn;
        logic               nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        logic signed [16:0] mag_l;
        sgn    = a_q[15] ^ b_q[15];
        nan_a  = (a_q[14:10] == 5'h1F) && (a_q[9:0] != 10'h0);
        nan_b  = (b_q[14:10] == 5'h1F) && (b_q[9:0] != 10'h0);
        inf_a  = (a_q[14:10] == 5'h1F) && (a_q[9:0] == 10'h0);
        inf_b  = (b_q[14:10] == 5'h1F) && (b_q[9:0] == 10'h0);
        // Subnormals are flushed, so any e=0 operand behaves as zero.
        zero_a = (a_q[14:10] == 5'h00);
        zero_b = (b_q[14:10] == 5'h00);
        // Adding packed exp|frac fields is a log2 add; mantissa carry rolls
        // into the exponent, which is the Mitchell antilog approximation.
        mag_l  = $signed({2'b00, a_q[14:0]}) + $signed({2'b00, b_q[14:0]}) - BiasL;
        prod   = {sgn, mag_l[14:0]};
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            prod = QNaN;
        end else if (inf_a || inf_b) begin
            prod = {sgn, 15'h7C00};
        end else if (zero_a || zero_b) begin
            prod = {sgn, 15'h0000};
        end else if (mag_l >= OvfL) begin
            prod = {sgn, 15'h7C00};
        end else if (mag_l < UnfL) begin
            prod = {sgn, 15'h0000};
        end
    end

    // Frame sequencing and operand/result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        uo_d    = uo_q;
        unique case (state_q)
            StLoadLo: begin
                a_d[7:0] = ui_in;
                b_d[7:0] = uio_in;
                state_d  = StLoadHi;
            end
            StLoadHi: begin
                a_d[15:8] = ui_in;
                b_d[15:8] = uio_in;
                state_d   = StOutLo;
            end
            StOutLo: begin
                p_d     = prod;
                uo_d    = prod[7:0];
                state_d = StOutHi;
            end
            StOutHi: begin
                uo_d    = p_q[15:8];
                state_d = StLoadLo;
            end
            default: state_d = StLoadLo;
        endcase
    end

    // State registers: synchronous active-low reset, hold while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StLoadLo;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            p_q     <= 16'h0000;
            uo_q    <= 8'h00;
        end else if (ena) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            uo_q    <= uo_d;
        end
    end

    assign uo_out  = uo_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_logarithmic_afpm.sv
// Directed self-checking bench for logarithmic_afpm. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising edge.
`timescale 1ns/1ps
module tb_logarithmic_afpm;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_pass;
    int n_total;

    logarithmic_afpm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One full frame starting from a falling edge; returns the two output bytes.
    task automatic run_frame(input logic [15:0] a, input logic [15:0] b,
                             output logic [7:0] lo, output logic [7:0] hi);
        ui_in  = a[7:0];
        uio_in = b[7:0];
        @(posedge clk); @(negedge clk);
        ui_in  = a[15:8];
        uio_in = b[15:8];
        @(posedge clk); @(negedge clk);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(posedge clk); @(negedge clk);
        lo = uo_out;
        @(posedge clk); @(negedge clk);
        hi = uo_out;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hFF;
        uio_in = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (uo_out !== 8'h00) $display("FAIL reset_uo_out got %h expected 00", uo_out);
        else n_pass++;
        n_total++;
        if (uio_out !== 8'h00) $display("FAIL reset_uio_out got %h expected 00", uio_out);
        else n_pass++;
        n_total++;
        if (uio_oe !== 8'h00) $display("FAIL reset_uio_oe got %h expected 00", uio_oe);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    // Ordinary products, including the spec examples, checked byte by byte.
    task automatic test_mult();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic [15:0] vp [5];
        logic [7:0]  lo, hi;
        va[0] = 16'h3E00; vb[0] = 16'h4200; vp[0] = 16'h4400; // 1.5*3 -> 4.0
        va[1] = 16'h3C00; vb[1] = 16'hC500; vp[1] = 16'hC500; // 1*-5
        va[2] = 16'h4000; vb[2] = 16'h4000; vp[2] = 16'h4400; // 2*2
        va[3] = 16'h4100; vb[3] = 16'h4100; vp[3] = 16'h4600; // 2.5*2.5 -> 6.0
        va[4] = 16'h4100; vb[4] = 16'h3C01; vp[4] = 16'h4101; // nonzero low byte
        for (int i = 0; i < 5; i++) begin
            run_frame(va[i], vb[i], lo, hi);
            n_total++;
            if (lo !== vp[i][7:0])
                $display("FAIL mult_lo[%0d] %h*%h got %h expected %h", i, va[i], vb[i],
                         lo, vp[i][7:0]);
            else n_pass++;
            n_total++;
            if (hi !== vp[i][15:8])
                $display("FAIL mult_hi[%0d] %h*%h got %h expected %h", i, va[i], vb[i],
                         hi, vp[i][15:8]);
            else n_pass++;
        end
    endtask

    task automatic test_specials();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic [15:0] vp [8];
        logic [7:0]  lo, hi;
        va[0] = 16'h0000; vb[0] = 16'h4200; vp[0] = 16'h0000; // zero
        va[1] = 16'h8000; vb[1] = 16'h3C00; vp[1] = 16'h8000; // signed zero
        va[2] = 16'h7C00; vb[2] = 16'h0000; vp[2] = 16'h7E00; // inf*0
        va[3] = 16'h7E01; vb[3] = 16'h3C00; vp[3] = 16'h7E00; // NaN
        va[4] = 16'h7C00; vb[4] = 16'h4000; vp[4] = 16'h7C00; // inf
        va[5] = 16'hFC00; vb[5] = 16'h4000; vp[5] = 16'hFC00; // -inf
        va[6] = 16'h7BFF; vb[6] = 16'h7BFF; vp[6] = 16'h7C00; // overflow
        va[7] = 16'h0400; vb[7] = 16'h0400; vp[7] = 16'h0000; // underflow
        for (int i = 0; i < 8; i++) begin
            run_frame(va[i], vb[i], lo, hi);
            n_total++;
            if ({hi, lo} !== vp[i])
                $display("FAIL special[%0d] %h*%h got %h expected %h", i, va[i], vb[i],
                         {hi, lo}, vp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] lo, hi;
        run_frame(16'h4000, 16'h4200, lo, hi); // 2*3 = 6
        n_total++;
        if ({hi, lo} !== 16'h4600) $display("FAIL b2b_first got %h expected 4600", {hi, lo});
        else n_pass++;
        run_frame(16'h3800, 16'hC000, lo, hi); // 0.5*-2 = -1
        n_total++;
        if (lo !== 8'h00) $display("FAIL b2b_second_lo got %h expected 00", lo);
        else n_pass++;
        n_total++;
        if (hi !== 8'hBC) $display("FAIL b2b_second_hi got %h expected bc", hi);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] lo, hi;
        run_frame(16'h3E00, 16'h4200, lo, hi); // leaves uo_out = 44
        // Load low bytes, then reset while in LOAD_HI.
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(posedge clk); @(negedge clk);
        rst_n  = 1'b0;
        ui_in  = 8'h45;
        uio_in = 8'h45;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (uo_out !== 8'h00) $display("FAIL midreset_uo_out got %h expected 00", uo_out);
        else n_pass++;
        rst_n = 1'b1;
        run_frame(16'h3C00, 16'hC500, lo, hi);
        n_total++;
        if ({hi, lo} !== 16'hC500)
            $display("FAIL midreset_restart got %h expected c500", {hi, lo});
        else n_pass++;
    endtask

    task automatic test_enable_freeze();
        logic [7:0] lo, hi;
        run_frame(16'h3E00, 16'h4200, lo, hi); // leaves uo_out = 44
        ui_in  = 8'h00;  // A = 4100 low byte
        uio_in = 8'h01;  // B = 3C01 low byte
        @(posedge clk); @(negedge clk);
        ena    = 1'b0;
        ui_in  = 8'hAA;
        uio_in = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            n_total++;
            if (uo_out !== 8'h44)
                $display("FAIL freeze_uo_out[%0d] got %h expected 44", i, uo_out);
            else n_pass++;
        end
        ena    = 1'b1;
        ui_in  = 8'h41;
        uio_in = 8'h3C;
        @(posedge clk); @(negedge clk);
        ui_in  = 8'h00;
        uio_in = 8'h00;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (uo_out !== 8'h01) $display("FAIL freeze_result_lo got %h expected 01", uo_out);
        else n_pass++;
        @(posedge clk); @(negedge clk);
        n_total++;
        if (uo_out !== 8'h41) $display("FAIL freeze_result_hi got %h expected 41", uo_out);
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        ena     = 1'b1;
        ui_in   = 8'h00;
        uio_in  = 8'h00;
        @(negedge clk);
        test_reset();
        test_mult();
        test_specials();
        test_back_to_back();
        test_reset_mid_frame();
        test_enable_freeze();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
